// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the VGA pipeline (timing gen, color_mem, vga_driver).
// Default mode is 800x600@60 at a 40 MHz pixel clock; counter widths are fixed by the ports.
// No logic here: constants and a total-length helper only.
package vga_timing_gen_pkg;

    localparam int HCNT_W   = 11;
    localparam int VCNT_W   = 10;
    localparam int HCNT_MAX = 1 << HCNT_W;
    localparam int VCNT_MAX = 1 << VCNT_W;

    localparam int DEF_HRES = 800;
    localparam int DEF_HFP  = 40;
    localparam int DEF_HSW  = 128;
    localparam int DEF_HBP  = 88;
    localparam int DEF_VRES = 600;
    localparam int DEF_VFP  = 1;
    localparam int DEF_VSW  = 4;
    localparam int DEF_VBP  = 23;

    function automatic int axis_total(input int active, input int fp, input int sw, input int bp);
        return active + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered display/sync decodes.
// Latency: count, disp and sync all update on the same step edge (decoded from next count).
// Backpressure: none; step low freezes every output, so pulses stretch with the enable.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int W          = HCNT_W,
    parameter int TOTAL      = 1056,
    parameter int ACTIVE     = 800,
    parameter int SYNC_START = 840,
    parameter int SYNC_LEN   = 128,
    parameter bit POL        = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         disp,
    output logic         sync,
    output logic         wrap
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_END = W'(SYNC_START + SYNC_LEN);

    logic [W-1:0] count_nxt;
    logic         sync_act_nxt;

    assign wrap         = (count == LAST);
    assign count_nxt    = wrap ? '0 : count + 1'b1;
    assign sync_act_nxt = (count_nxt >= SYNC_BEG) && (count_nxt < SYNC_END);

    // Outputs are decoded from count_nxt so they line up with count without skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
            disp  <= 1'b0;
            sync  <= ~POL;
        end else if (step) begin
            count <= count_nxt;
            disp  <= (count_nxt < ACT_END);
            sync  <= sync_act_nxt ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hsync/vsync, display windows, pixel coordinates, line/frame starts.
// Latency: all outputs are flops stepping together on each enabled edge; zero skew between them.
// Backpressure: none; pix_en low holds every counter and output.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int HRES      = DEF_HRES,
    parameter int HFP       = DEF_HFP,
    parameter int HSW       = DEF_HSW,
    parameter int HBP       = DEF_HBP,
    parameter int VRES      = DEF_VRES,
    parameter int VFP       = DEF_VFP,
    parameter int VSW       = DEF_VSW,
    parameter int VBP       = DEF_VBP,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    output logic              hsync,
    output logic              vsync,
    output logic              hdisp,
    output logic              vdisp,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              line_start,
    output logic              frame_start
);

    localparam int HTOTAL = axis_total(HRES, HFP, HSW, HBP);
    localparam int VTOTAL = axis_total(VRES, VFP, VSW, VBP);

    generate
        if (HTOTAL > HCNT_MAX || VTOTAL > VCNT_MAX ||
            HFP < 1 || HSW < 1 || HBP < 1 || VFP < 1 || VSW < 1 || VBP < 1) begin : g_bad_params
            $error("vga_timing_gen: totals exceed counter width or a porch/sync length is zero");
        end
    endgenerate

    logic h_wrap;
    logic v_wrap;
    logic v_step;

    assign v_step = pix_en & h_wrap;

    vga_axis_counter #(
        .W          (HCNT_W),
        .TOTAL      (HTOTAL),
        .ACTIVE     (HRES),
        .SYNC_START (HRES + HFP),
        .SYNC_LEN   (HSW),
        .POL        (HSYNC_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_en),
        .count (hcount),
        .disp  (hdisp),
        .sync  (hsync),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .W          (VCNT_W),
        .TOTAL      (VTOTAL),
        .ACTIVE     (VRES),
        .SYNC_START (VRES + VFP),
        .SYNC_LEN   (VSW),
        .POL        (VSYNC_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (v_step),
        .count (vcount),
        .disp  (vdisp),
        .sync  (vsync),
        .wrap  (v_wrap)
    );

    // A wrap on this edge means the next position is column 0 (and row 0 if V wraps too).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

endmodule
